seq_det_ctrl: RTL

- Controller and sequencer for the serial pattern-detector datapath.
- Accepts a pattern, length and match target through a valid/ready config handshake, then arms on start.
- Samples the serial bit stream, pulses match on each detected occurrence, counts matches, and stops in DONE when the target is reached.
- Sits between the host/config logic and the serial input line; replaces fixed-pattern detectors with one programmable, sequenced block.

---
 rtl/seq_det_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detector controller: config handshake, arm/abort sequencing, match counting.
// Optional build macro SEQCTRL_OVERLAP_EN: when defined, overlapping occurrences are counted.
module seq_det_ctrl #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int unsigned LEN_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_sr;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_count;
  logic             r_match;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_ready;

  state_t           w_state_nxt;
  logic [PAT_W-1:0] w_sr_nxt;
  logic [LEN_W-1:0] w_fill_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_match_nxt;

  logic             w_cfg_acc;
  logic [LEN_W-1:0] w_len_clamp;
  logic [PAT_W-1:0] w_sr_shift;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W:0]   w_fill_p1;
  logic             w_full;
  logic             w_hit;
  logic [CNT_W-1:0] w_count_inc;

  assign w_cfg_acc   = cfg_valid && r_cfg_ready;
  assign w_len_clamp = (cfg_len == '0) ? LEN_W'(1) :
                       (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  // Mask wraps to all-ones when len == PAT_W.
  assign w_sr_shift  = {r_sr[PAT_W-2:0], x};
  assign w_mask      = (PAT_W'(1) << r_len) - PAT_W'(1);
  assign w_fill_p1   = (LEN_W+1)'(r_fill) + (LEN_W+1)'(1);
  assign w_full      = w_fill_p1 >= (LEN_W+1)'(r_len);
  assign w_hit       = (r_state == S_RUN) && x_valid && !abort && w_full &&
                       ((w_sr_shift & w_mask) == (r_pattern & w_mask));
  assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_fill_nxt  = r_fill;
    w_count_nxt = r_count;
    w_match_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_sr_nxt    = '0;
          w_fill_nxt  = '0;
          w_count_nxt = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (x_valid) begin
          w_sr_nxt   = w_sr_shift;
          w_fill_nxt = w_full ? r_len : r_fill + LEN_W'(1);
          if (w_hit) begin
            w_match_nxt = 1'b1;
            w_count_nxt = w_count_inc;
`ifndef SEQCTRL_OVERLAP_EN
            w_fill_nxt  = '0;
`endif
            if ((r_target != '0) && (w_count_inc == r_target)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_RUN;
          w_sr_nxt    = '0;
          w_fill_nxt  = '0;
          w_count_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_fill      <= '0;
      r_pattern   <= '0;
      r_len       <= LEN_W'(1);
      r_target    <= '0;
      r_count     <= '0;
      r_match     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_fill      <= w_fill_nxt;
      r_count     <= w_count_nxt;
      r_match     <= w_match_nxt;
      r_busy      <= (w_state_nxt == S_RUN);
      r_done      <= (w_state_nxt == S_DONE);
      r_cfg_ready <= (w_state_nxt != S_RUN);
      if (w_cfg_acc) begin
        r_pattern <= cfg_pattern;
        r_len     <= w_len_clamp;
        r_target  <= cfg_target;
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign match     = r_match;
  assign count     = r_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state     = r_state;

endmodule
